roulette_reader: RTL

- Reads the roulette display from the other end. It samples the active-low 7-segment pattern that the spinner drives onto HEX0, plus a push button.
- On a debounced press it freezes the spinner, decodes the lit segment to a position index, compares that index with a player target, and keeps a score.
- It sits beside the spinner in the top level. It takes the HEX0 segment bus and a KEY input, and drives the spinner's run enable.

---
 rtl/roulette_reader_if.sv | 25 ++
 rtl/roulette_reader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/roulette_reader_if.sv
// Bus between the roulette reader and its surroundings: HEX0 segment bus,
// push button, player target and the reader's results.
interface roulette_reader_if #(
    parameter int SCORE_W = 8
);
    logic [6:0]         seg_n;
    logic               key_n;
    logic [2:0]         target;
    logic               run;
    logic [2:0]         pos;
    logic               pos_valid;
    logic               hit;
    logic               seg_err;
    logic [SCORE_W-1:0] score;

    modport master (
        output seg_n, key_n, target,
        input  run, pos, pos_valid, hit, seg_err, score
    );

    modport slave (
        input  seg_n, key_n, target,
        output run, pos, pos_valid, hit, seg_err, score
    );
endinterface

// File: rtl/roulette_reader.sv
// Reads the spinner's HEX0 pattern on a debounced key press, freezes the
// spinner, reports the captured position and keeps a saturating hit score.
//
// state | meaning
// SPIN  | spinner running (run=1); a press tries to capture the lit segment
// HOLD  | spinner frozen (run=0); pos/hit held; a press resumes spinning
module roulette_reader #(
    parameter int DEB_CYCLES = 500000,
    parameter int SCORE_W    = 8
) (
    input  logic clk,
    input  logic rst,
    roulette_reader_if.slave bus
);
    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic {SPIN, HOLD} state_t;

    state_t             state, state_nxt;
    logic               key_m, key_s, key_d, key_d_q, press;
    logic [CNT_W-1:0]   deb_cnt;
    logic [6:0]         seg;
    logic [2:0]         ones, seg_idx, dec_idx;
    logic               seg_legal, dec_valid;
    logic [2:0]         pos_r, pos_nxt;
    logic               pos_valid_r, pos_valid_nxt;
    logic               hit_r, hit_nxt, cap_hit;
    logic               seg_err_r, seg_err_nxt;
    logic [SCORE_W-1:0] score_r, score_nxt;

    // Synchroniser, debouncer and falling-edge press detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_m   <= 1'b1;
            key_s   <= 1'b1;
            key_d   <= 1'b1;
            key_d_q <= 1'b1;
            press   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            key_m   <= bus.key_n;
            key_s   <= key_m;
            key_d_q <= key_d;
            press   <= key_d_q & ~key_d;
            if (key_s == key_d) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_TC) begin
                key_d   <= key_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        seg     = ~bus.seg_n;
        ones    = '0;
        seg_idx = '0;
        for (int i = 0; i < 6; i++) begin
            if (seg[i]) begin
                ones    = ones + 3'd1;
                seg_idx = 3'(i);
            end
        end
        seg_legal = !seg[6] && (ones == 3'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_valid <= 1'b0;
            dec_idx   <= '0;
        end else begin
            dec_valid <= seg_legal;
            dec_idx   <= seg_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SPIN;
            pos_r       <= '0;
            pos_valid_r <= 1'b0;
            hit_r       <= 1'b0;
            seg_err_r   <= 1'b0;
            score_r     <= '0;
        end else begin
            state       <= state_nxt;
            pos_r       <= pos_nxt;
            pos_valid_r <= pos_valid_nxt;
            hit_r       <= hit_nxt;
            seg_err_r   <= seg_err_nxt;
            score_r     <= score_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pos_nxt       = pos_r;
        pos_valid_nxt = 1'b0;
        hit_nxt       = hit_r;
        seg_err_nxt   = seg_err_r;
        score_nxt     = score_r;
        cap_hit       = (dec_idx == bus.target);
        case (state)
            SPIN: begin
                if (press) begin
                    if (dec_valid) begin
                        pos_nxt       = dec_idx;
                        pos_valid_nxt = 1'b1;
                        hit_nxt       = cap_hit;
                        seg_err_nxt   = 1'b0;
                        state_nxt     = HOLD;
                        if (cap_hit && (score_r != '1))
                            score_nxt = score_r + 1'b1;
                    end else begin
                        seg_err_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (press) begin
                    hit_nxt   = 1'b0;
                    state_nxt = SPIN;
                end
            end
            default: state_nxt = SPIN;
        endcase
    end

    assign bus.run       = (state == SPIN);
    assign bus.pos       = pos_r;
    assign bus.pos_valid = pos_valid_r;
    assign bus.hit       = hit_r;
    assign bus.seg_err   = seg_err_r;
    assign bus.score     = score_r;
endmodule
